// File: rtl/sim_mon_pkg.sv
// Shared types and defaults for the end-of-run bus monitor.
// Holds the FSM state encoding, default addresses/data and helpers.
package sim_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_PASS_SEEN = 3'd2,
      ST_PASS      = 3'd3,
      ST_FAIL      = 3'd4,
      ST_TOUT      = 3'd5
   } state_e;

   localparam logic [31:0] DEF_HALT_ADDR = 32'h0000_00b8;
   localparam logic [31:0] DEF_PASS_ADDR = 32'h0000_0064;
   localparam logic [31:0] DEF_PASS_DATA = 32'h0000_0007;
   localparam int          DEF_TIMEOUT   = 1000;

   // States still watching the bus.
   function automatic logic is_active(input state_e s);
      return (s == ST_RUN) || (s == ST_PASS_SEEN);
   endfunction

   // Absorbing verdict states.
   function automatic logic is_terminal(input state_e s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TOUT);
   endfunction

endpackage

// File: rtl/sim_end_monitor_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Ports: clk, clr (sync clear), en (count enable), count (value).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Holds at all-ones instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (en && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sim_end_monitor.sv
// End-of-run monitor: watches the processor data bus for a pass
// signature store, a halt-address access or a cycle timeout and
// latches a sticky verdict with cycle/write statistics.
// Ports: clk, reset (sync, active-high), Adr/WriteData/MemWrite (bus),
// done/pass/fail/timeout (verdict), state, cycle_count, write_count,
// fail_addr/fail_data (bus values captured at the failing event).
module sim_end_monitor
   import sim_mon_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                CNT_W     = 32,
   parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(DEF_HALT_ADDR),
   parameter bit                CHECK_EN  = 1'b1,
   parameter logic [ADDR_W-1:0] PASS_ADDR = ADDR_W'(DEF_PASS_ADDR),
   parameter logic [DATA_W-1:0] PASS_DATA = DATA_W'(DEF_PASS_DATA),
   parameter int                TIMEOUT   = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Adr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MemWrite,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  write_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   localparam bit             TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] fail_addr_q;
   logic [ADDR_W-1:0] fail_addr_d;
   logic [DATA_W-1:0] fail_data_q;
   logic [DATA_W-1:0] fail_data_d;
   logic              done_q;
   logic              done_d;
   logic              pass_q;
   logic              pass_d;
   logic              fail_q;
   logic              fail_d;
   logic              tout_q;
   logic              tout_d;

   logic              active;
   logic              sig_hit;
   logic              sig_ok;
   logic              halt_hit;
   logic              to_hit;

   assign active   = is_active(state_q);
   assign sig_hit  = MemWrite && (Adr == PASS_ADDR);
   assign sig_ok   = (WriteData == PASS_DATA);
   assign halt_hit = (Adr == HALT_ADDR);
   // Compare against the pre-increment count: the edge that sees
   // TIMEOUT-1 is the TIMEOUT-th edge spent watching the bus.
   assign to_hit   = TO_EN && (cycle_count == TO_LAST);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         tout_q      <= tout_d;
      end
   end

   // Next state; signature check outranks halt, halt outranks timeout.
   always_comb begin
      state_d     = state_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_RUN;
         end
         ST_RUN, ST_PASS_SEEN: begin
            if (sig_hit) begin
               if (sig_ok) begin
                  state_d = CHECK_EN ? ST_PASS_SEEN : ST_PASS;
               end else begin
                  state_d     = ST_FAIL;
                  fail_addr_d = Adr;
                  fail_data_d = WriteData;
               end
            end else if (halt_hit) begin
               if (!CHECK_EN || (state_q == ST_PASS_SEEN)) begin
                  state_d = ST_PASS;
               end else begin
                  state_d     = ST_FAIL;
                  fail_addr_d = Adr;
               end
            end else if (to_hit) begin
               state_d     = ST_TOUT;
               fail_addr_d = Adr;
            end
         end
         ST_PASS, ST_FAIL, ST_TOUT: begin
            state_d = state_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Verdict flags follow the state being entered on this edge.
   always_comb begin
      done_d = is_terminal(state_d);
      pass_d = (state_d == ST_PASS);
      fail_d = (state_d == ST_FAIL);
      tout_d = (state_d == ST_TOUT);
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .clr   (reset),
      .en    (active),
      .count (cycle_count)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_write_cnt (
      .clk   (clk),
      .clr   (reset),
      .en    (active && MemWrite),
      .count (write_count)
   );

   assign state     = state_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = tout_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;

endmodule

// File: tb/tb_sim_end_monitor.sv
// Directed bench for sim_end_monitor over four parameter sets
// sharing one bus, each held in reset while another is exercised.
module tb_sim_end_monitor;

   logic        clk;
   logic        rst_a;
   logic        rst_b;
   logic        rst_c;
   logic        rst_e;
   logic [31:0] adr;
   logic [31:0] wd;
   logic        mw;

   int n_cmp;
   int n_bad;

   logic        a_done, a_pass, a_fail, a_tout;
   logic [2:0]  a_state;
   logic [31:0] a_cyc, a_wr, a_fa, a_fd;
   logic        b_done, b_pass, b_fail, b_tout;
   logic [2:0]  b_state;
   logic [31:0] b_cyc, b_wr, b_fa, b_fd;
   logic        c_done, c_pass, c_fail, c_tout;
   logic [2:0]  c_state;
   logic [31:0] c_cyc, c_wr, c_fa, c_fd;
   logic        e_done, e_pass, e_fail, e_tout;
   logic [2:0]  e_state;
   logic [3:0]  e_cyc, e_wr;
   logic [31:0] e_fa, e_fd;

   sim_end_monitor #(
      .CHECK_EN (1'b1),
      .TIMEOUT  (1000)
   ) u_a (
      .clk (clk), .reset (rst_a),
      .Adr (adr), .WriteData (wd), .MemWrite (mw),
      .done (a_done), .pass (a_pass), .fail (a_fail),
      .timeout (a_tout), .state (a_state),
      .cycle_count (a_cyc), .write_count (a_wr),
      .fail_addr (a_fa), .fail_data (a_fd)
   );

   sim_end_monitor #(
      .CHECK_EN (1'b0),
      .TIMEOUT  (0)
   ) u_b (
      .clk (clk), .reset (rst_b),
      .Adr (adr), .WriteData (wd), .MemWrite (mw),
      .done (b_done), .pass (b_pass), .fail (b_fail),
      .timeout (b_tout), .state (b_state),
      .cycle_count (b_cyc), .write_count (b_wr),
      .fail_addr (b_fa), .fail_data (b_fd)
   );

   sim_end_monitor #(
      .CHECK_EN (1'b1),
      .TIMEOUT  (50)
   ) u_c (
      .clk (clk), .reset (rst_c),
      .Adr (adr), .WriteData (wd), .MemWrite (mw),
      .done (c_done), .pass (c_pass), .fail (c_fail),
      .timeout (c_tout), .state (c_state),
      .cycle_count (c_cyc), .write_count (c_wr),
      .fail_addr (c_fa), .fail_data (c_fd)
   );

   sim_end_monitor #(
      .CNT_W    (4),
      .CHECK_EN (1'b1),
      .TIMEOUT  (0)
   ) u_e (
      .clk (clk), .reset (rst_e),
      .Adr (adr), .WriteData (wd), .MemWrite (mw),
      .done (e_done), .pass (e_pass), .fail (e_fail),
      .timeout (e_tout), .state (e_state),
      .cycle_count (e_cyc), .write_count (e_wr),
      .fail_addr (e_fa), .fail_data (e_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      adr = 32'h0;
      wd  = 32'h0;
      mw  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      rst_e = 1'b1;
      idle_bus();

      // Reset with random bus traffic.
      repeat (3) begin
         adr = $urandom;
         wd  = $urandom;
         mw  = 1'($urandom);
         tick();
      end
      chk("rst_state", 64'(a_state), 64'd0);
      chk("rst_done", 64'(a_done), 64'd0);
      chk("rst_pass", 64'(a_pass), 64'd0);
      chk("rst_fail", 64'(a_fail), 64'd0);
      chk("rst_tout", 64'(a_tout), 64'd0);
      chk("rst_cyc", 64'(a_cyc), 64'd0);
      chk("rst_wr", 64'(a_wr), 64'd0);
      chk("rst_fa", 64'(a_fa), 64'd0);
      chk("rst_fd", 64'(a_fd), 64'd0);

      // Release: first edge enters RUN, count starts at 0.
      idle_bus();
      rst_a = 1'b0;
      tick();
      chk("arm_state", 64'(a_state), 64'd1);
      chk("arm_cyc", 64'(a_cyc), 64'd0);
      repeat (10) tick();
      chk("run_cyc10", 64'(a_cyc), 64'd10);

      // Good signature at RUN cycle 10.
      adr = 32'h64; wd = 32'h7; mw = 1'b1;
      tick();
      idle_bus();
      chk("sig_state", 64'(a_state), 64'd2);
      chk("sig_wr", 64'(a_wr), 64'd1);
      chk("sig_cyc", 64'(a_cyc), 64'd11);
      chk("sig_done", 64'(a_done), 64'd0);
      repeat (9) tick();
      chk("pre_halt_cyc", 64'(a_cyc), 64'd20);

      // Halt read at RUN cycle 20.
      adr = 32'hb8;
      tick();
      idle_bus();
      chk("halt_state", 64'(a_state), 64'd3);
      chk("halt_pass", 64'(a_pass), 64'd1);
      chk("halt_done", 64'(a_done), 64'd1);
      chk("halt_fail", 64'(a_fail), 64'd0);
      chk("halt_cyc", 64'(a_cyc), 64'd21);
      adr = 32'h64; wd = 32'h1; mw = 1'b1;
      repeat (5) tick();
      idle_bus();
      chk("pass_frz_cyc", 64'(a_cyc), 64'd21);
      chk("pass_frz_wr", 64'(a_wr), 64'd1);
      chk("pass_sticky", 64'(a_state), 64'd3);

      // Wrong signature.
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      tick();
      chk("rearm_state", 64'(a_state), 64'd1);
      adr = 32'h64; wd = 32'h5; mw = 1'b1;
      tick();
      chk("bad_state", 64'(a_state), 64'd4);
      chk("bad_fail", 64'(a_fail), 64'd1);
      chk("bad_pass", 64'(a_pass), 64'd0);
      chk("bad_fa", 64'(a_fa), 64'h64);
      chk("bad_fd", 64'(a_fd), 64'd5);
      chk("bad_wr", 64'(a_wr), 64'd1);
      adr = 32'h10; wd = 32'h9; mw = 1'b1;
      repeat (3) tick();
      idle_bus();
      chk("fail_frz_wr", 64'(a_wr), 64'd1);
      chk("fail_frz_fa", 64'(a_fa), 64'h64);
      chk("fail_frz_fd", 64'(a_fd), 64'd5);

      // Reset asserted while in FAIL.
      rst_a = 1'b1;
      tick();
      chk("rfail_state", 64'(a_state), 64'd0);
      chk("rfail_fail", 64'(a_fail), 64'd0);
      chk("rfail_done", 64'(a_done), 64'd0);
      chk("rfail_fa", 64'(a_fa), 64'd0);
      chk("rfail_fd", 64'(a_fd), 64'd0);
      chk("rfail_wr", 64'(a_wr), 64'd0);
      chk("rfail_cyc", 64'(a_cyc), 64'd0);

      // Halt with no signature, CHECK_EN=1.
      rst_a = 1'b0;
      tick();
      repeat (3) tick();
      adr = 32'hb8;
      tick();
      idle_bus();
      chk("nosig_state", 64'(a_state), 64'd4);
      chk("nosig_fail", 64'(a_fail), 64'd1);
      chk("nosig_fa", 64'(a_fa), 64'hb8);
      rst_a = 1'b1;

      // TIMEOUT=0: no verdict after 10000 cycles.
      rst_b = 1'b0;
      tick();
      repeat (10000) tick();
      chk("noto_done", 64'(b_done), 64'd0);
      chk("noto_state", 64'(b_state), 64'd1);
      chk("noto_cyc", 64'(b_cyc), 64'd10000);

      // CHECK_EN=0: halt alone passes.
      adr = 32'hb8;
      tick();
      idle_bus();
      chk("ce0_halt_state", 64'(b_state), 64'd3);
      chk("ce0_halt_pass", 64'(b_pass), 64'd1);
      chk("ce0_halt_fail", 64'(b_fail), 64'd0);

      // CHECK_EN=0: good signature passes directly.
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      tick();
      adr = 32'h64; wd = 32'h7; mw = 1'b1;
      tick();
      idle_bus();
      chk("ce0_sig_state", 64'(b_state), 64'd3);
      chk("ce0_sig_pass", 64'(b_pass), 64'd1);
      chk("ce0_sig_wr", 64'(b_wr), 64'd1);
      rst_b = 1'b1;

      // TIMEOUT=50 on an idle bus parked at 0x20.
      rst_c = 1'b0;
      adr = 32'h20;
      tick();
      repeat (49) tick();
      chk("to_pre_state", 64'(c_state), 64'd1);
      chk("to_pre_cyc", 64'(c_cyc), 64'd49);
      tick();
      chk("to_state", 64'(c_state), 64'd5);
      chk("to_flag", 64'(c_tout), 64'd1);
      chk("to_done", 64'(c_done), 64'd1);
      chk("to_pass", 64'(c_pass), 64'd0);
      chk("to_cyc", 64'(c_cyc), 64'd50);
      chk("to_fa", 64'(c_fa), 64'h20);

      // Signature coincident with the timeout edge.
      idle_bus();
      rst_c = 1'b1;
      tick();
      rst_c = 1'b0;
      tick();
      repeat (49) tick();
      adr = 32'h64; wd = 32'h7; mw = 1'b1;
      tick();
      idle_bus();
      chk("coinc_state", 64'(c_state), 64'd2);
      chk("coinc_tout", 64'(c_tout), 64'd0);
      chk("coinc_cyc", 64'(c_cyc), 64'd50);
      repeat (5) tick();
      chk("coinc_hold", 64'(c_state), 64'd2);
      adr = 32'hb8;
      tick();
      idle_bus();
      chk("coinc_pass", 64'(c_pass), 64'd1);
      rst_c = 1'b1;

      // CNT_W=4: 20 stores saturate both counters at 15.
      rst_e = 1'b0;
      tick();
      adr = 32'h10; wd = 32'h1; mw = 1'b1;
      repeat (20) tick();
      idle_bus();
      chk("sat_wr", 64'(e_wr), 64'd15);
      chk("sat_cyc", 64'(e_cyc), 64'd15);
      chk("sat_state", 64'(e_state), 64'd1);
      rst_e = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sim_end_monitor.md
Name: sim_end_monitor

Overview:
- Parametrised, synthesizable end-of-run monitor for the multicycle processor data bus. It observes Adr/WriteData/MemWrite from top and detects: a pass-signature store, a halt-address access, or a cycle timeout.
- It latches a sticky verdict with cycle and write statistics, so benches and FPGA builds share one termination/checking mechanism.

Parameters:
- ADDR_W, 32, width of Adr
- DATA_W, 32, width of WriteData
- CNT_W, 32, width of cycle and write counters
- HALT_ADDR, 32'hb8, any bus access to this address ends the run
- CHECK_EN, 1, 1 = a pass-signature store is required before halt; 0 = halt alone means pass
- PASS_ADDR, 32'h64, address of the signature store
- PASS_DATA, 32'h7, expected signature value
- TIMEOUT, 1000, cycles in RUN before the timeout verdict; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Adr  in  ADDR_W  processor memory address
- WriteData  in  DATA_W  processor store data
- MemWrite  in  1  store strobe
- done  out  1  verdict reached (sticky)
- pass  out  1  run passed (sticky)
- fail  out  1  wrong signature, or halt before signature (sticky)
- timeout  out  1  timeout expired (sticky)
- state  out  3  FSM state encoding, from the package
- cycle_count  out  CNT_W  cycles spent in RUN, saturating
- write_count  out  CNT_W  MemWrite cycles seen in RUN, saturating
- fail_addr  out  ADDR_W  Adr captured at the fail or timeout event
- fail_data  out  DATA_W  WriteData captured at the fail event

Behaviour:
- Reset is synchronous and active-high. While reset=1 at a rising clk edge: state=IDLE, and all outputs and counters are 0.
- IDLE -> RUN on the first edge with reset=0. Bus inputs are ignored in IDLE.
- RUN, evaluated each rising edge, highest priority first:
  - MemWrite=1 and Adr==PASS_ADDR:
    - WriteData==PASS_DATA -> PASS_SEEN if CHECK_EN=1, or PASS if CHECK_EN=0.
    - Otherwise -> FAIL, capturing fail_addr and fail_data.
  - Adr==HALT_ADDR (read or write) -> PASS if CHECK_EN=0, else FAIL, capturing fail_addr.
  - TIMEOUT!=0 and cycle_count==TIMEOUT-1 -> TOUT, capturing fail_addr=Adr.
  - Otherwise stay in RUN.
- PASS_SEEN: same rules as RUN, except a halt access -> PASS. A second signature store with wrong data -> FAIL. Timeout still applies.
- Terminal states are PASS, FAIL and TOUT. They are absorbing until reset. In them, counters freeze and all bus activity is ignored.
- Outputs are registered and take effect on the same edge as the state transition (1-cycle latency from the bus sample):
  - done=1 in any terminal state.
  - pass, fail and timeout are one-hot with their state.
- cycle_count increments on every edge spent in RUN or PASS_SEEN, including the edge that causes the transition out. It saturates at 2^CNT_W-1 and never wraps.
- write_count increments on each MemWrite=1 edge in RUN or PASS_SEEN, including the terminal edge. It saturates.
- Simultaneous events in one cycle: resolved by the priority above.
  - A store of PASS_DATA to PASS_ADDR that coincides with timeout goes to PASS_SEEN, not TOUT.
  - With PASS_ADDR==HALT_ADDR, the signature check wins.
- Reset mid-run, or in a terminal state: next edge gives IDLE with all outputs cleared. The monitor re-arms one cycle after reset deasserts.
- Bus inputs are sampled only at the rising edge. Glitches between edges are irrelevant.

Decomposition:
- Package sim_mon_pkg holds:
  - the state typedef: IDLE=0, RUN=1, PASS_SEEN=2, PASS=3, FAIL=4, TOUT=5;
  - the default address and data constants.
- One sub-module, sat_counter: parametrised width, with en and synchronous clear. It is instantiated twice, for cycle_count and write_count.

Test Plan:
- reset held 3 cycles with random bus activity -> state=IDLE, all outputs 0. The first edge after release -> RUN, and cycle_count counts from 0.
- CHECK_EN=1: store 7 to 0x64 at RUN cycle 10, then read 0xb8 at cycle 20 -> state=PASS_SEEN after the store; pass=1, done=1 after the read; cycle_count frozen at 21.
- CHECK_EN=1: store 5 to 0x64 -> fail=1, fail_addr=0x64, fail_data=5. Further stores leave write_count unchanged.
- halt read of 0xb8 with no prior signature -> CHECK_EN=0 gives pass=1; CHECK_EN=1 gives fail=1 with fail_addr=0xb8.
- TIMEOUT=50, idle bus -> timeout=1 on RUN cycle 50, cycle_count=50. With TIMEOUT=0, there is still no verdict after 10000 cycles.
- CNT_W=4, 20 stores to 0x10 -> write_count saturates at 15. A signature store coincident with timeout -> PASS_SEEN. Reset asserted in FAIL -> all outputs clear on the next edge.
